// File: rtl/maze_arb.sv
// Round-robin arbiter that shares one serial maze solver between two requesters.
// Maze bits and solver directions are forwarded one cycle late; there is no backpressure, so a stalled load or a silent solver aborts with err.
module maze_arb #(
  parameter int MAZE_CELLS = 289,
  parameter int TIMEOUT    = 4095
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       in_valid0,
  input  logic       in_valid1,
  input  logic       in0,
  input  logic       in1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       slv_in_valid,
  output logic       slv_in,
  input  logic       slv_out_valid,
  input  logic [1:0] slv_out,
  output logic       out_valid0,
  output logic       out_valid1,
  output logic [1:0] out0,
  output logic [1:0] out1,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, LOAD, SOLVE, DRAIN} state_t;

  localparam logic [8:0]  LAST_CELL = 9'(MAZE_CELLS - 1);
  localparam logic [11:0] LAST_TICK = 12'(TIMEOUT - 1);

  state_t      state;
  logic [8:0]  cell_cnt;
  logic [11:0] tick_cnt;
  logic        owner;
  logic        last_served;
  logic        started;

  logic sel_vld;
  logic sel_bit;
  logic winner;
  logic load_abort;
  logic solve_timeout;
  logic drain_end;
  logic job_end;

  assign sel_vld = owner ? in_valid1 : in_valid0;
  assign sel_bit = owner ? in1 : in0;

  // With both requesting, the one not served last wins; a lone requester always wins.
  assign winner = (req0 && req1) ? ~last_served : req1;

  assign load_abort    = (state == LOAD) && started && !sel_vld;
  assign solve_timeout = (state == SOLVE) && !slv_out_valid && (tick_cnt == LAST_TICK);
  assign drain_end     = (state == DRAIN) && !slv_out_valid;
  assign job_end       = load_abort || solve_timeout || drain_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cell_cnt     <= '0;
      tick_cnt     <= '0;
      owner        <= 1'b0;
      last_served  <= 1'b1;
      started      <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      slv_in_valid <= 1'b0;
      slv_in       <= 1'b0;
      out_valid0   <= 1'b0;
      out_valid1   <= 1'b0;
      out0         <= 2'd0;
      out1         <= 2'd0;
    end else begin
      done         <= drain_end;
      err          <= load_abort | solve_timeout;
      slv_in_valid <= 1'b0;
      slv_in       <= 1'b0;
      out_valid0   <= 1'b0;
      out_valid1   <= 1'b0;
      out0         <= 2'd0;
      out1         <= 2'd0;

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner    <= winner;
            gnt0     <= ~winner;
            gnt1     <= winner;
            busy     <= 1'b1;
            cell_cnt <= '0;
            started  <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (sel_vld) begin
            slv_in_valid <= 1'b1;
            slv_in       <= sel_bit;
            started      <= 1'b1;
            cell_cnt     <= cell_cnt + 9'd1;
            if (cell_cnt == LAST_CELL) begin
              tick_cnt <= '0;
              state    <= SOLVE;
            end
          end
        end
        SOLVE: begin
          tick_cnt <= tick_cnt + 12'd1;
          if (slv_out_valid) state <= DRAIN;
        end
        default: begin
        end
      endcase

      if (state == SOLVE || state == DRAIN) begin
        if (owner) begin
          out_valid1 <= slv_out_valid;
          out1       <= slv_out;
        end else begin
          out_valid0 <= slv_out_valid;
          out0       <= slv_out;
        end
      end

      // Every job exit path releases the grant and remembers who was served.
      if (job_end) begin
        state       <= IDLE;
        gnt0        <= 1'b0;
        gnt1        <= 1'b0;
        busy        <= 1'b0;
        started     <= 1'b0;
        last_served <= owner;
      end
    end
  end

endmodule

// File: tb/tb_maze_arb.sv
// Randomized bench for maze_arb: round-robin model, stream scoreboards and directed job scenarios.
module tb_maze_arb;
  localparam int MAZE_CELLS = 289;
  localparam int TIMEOUT    = 4095;

  typedef logic [1:0] dir_q_t[$];
  typedef bit bit_q_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic       in0 = 1'b0, in1 = 1'b0;
  logic       slv_out_valid = 1'b0;
  logic [1:0] slv_out = 2'd0;
  logic       gnt0, gnt1, slv_in_valid, slv_in;
  logic       out_valid0, out_valid1;
  logic [1:0] out0, out1;
  logic       busy, done, err;

  always #5 clk = ~clk;

  maze_arb #(.MAZE_CELLS(MAZE_CELLS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in0(in0), .in1(in1),
    .gnt0(gnt0), .gnt1(gnt1),
    .slv_in_valid(slv_in_valid), .slv_in(slv_in),
    .slv_out_valid(slv_out_valid), .slv_out(slv_out),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out0(out0), .out1(out1),
    .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rr_last  = 1;

  bit_q_t slv_q, exp_bits;
  dir_q_t o_q0, o_q1, exp_d0, exp_d1;
  int     gnt_hist[$];
  int     done_n = 0, err_n = 0, both_n = 0, leak_n = 0, gap_bad = 0, hang_n = 0;
  logic   p_g0 = 1'b0, p_g1 = 1'b0, p_busy = 1'b0;

  // Observer: samples 1 time unit after each rising edge; tasks act at +2.
  always begin
    @(posedge clk);
    #1;
    if (slv_in_valid) slv_q.push_back(slv_in);
    if (slv_in_valid && !(p_g0 || p_g1)) leak_n++;
    if ((out_valid0 || out0 != 2'd0) && !p_g0) leak_n++;
    if ((out_valid1 || out1 != 2'd0) && !p_g1) leak_n++;
    if (gnt0 && gnt1) leak_n++;
    if (out_valid0) o_q0.push_back(out0);
    if (out_valid1) o_q1.push_back(out1);
    if (done) done_n++;
    if (err) err_n++;
    if (done && err) both_n++;
    if (gnt0 && !p_g0) begin gnt_hist.push_back(0); if (p_busy) gap_bad++; end
    if (gnt1 && !p_g1) begin gnt_hist.push_back(1); if (p_busy) gap_bad++; end
    p_g0 = gnt0; p_g1 = gnt1; p_busy = busy;
  end

  // Arbitration rule from the requirements, applied to the bench's own last-served record.
  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return (rr_last == 1) ? 0 : 1;
    return r0 ? 0 : 1;
  endfunction

  function automatic int diff_dirs(input dir_q_t a, input dir_q_t b);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic int diff_bits(input bit_q_t a, input bit_q_t b);
    if (a.size() != b.size()) return -2;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    slv_q.delete(); o_q0.delete(); o_q1.delete(); gnt_hist.delete();
    exp_bits.delete(); exp_d0.delete(); exp_d1.delete();
    done_n = 0; err_n = 0; both_n = 0; leak_n = 0; gap_bad = 0; hang_n = 0;
  endtask

  task automatic load_only(input int who, input int nbits, input int extra);
    for (int i = 0; i < nbits + extra; i++) begin
      logic b, nv, nb;
      b = 1'($urandom); nv = 1'($urandom); nb = 1'($urandom);
      if (who == 0) begin in_valid0 = 1'b1; in0 = b; in_valid1 = nv; in1 = nb; end
      else begin in_valid1 = 1'b1; in1 = b; in_valid0 = nv; in0 = nb; end
      if (i < nbits) exp_bits.push_back(b);
      step();
    end
    in_valid0 = 1'b0; in_valid1 = 1'b0; in0 = 1'b0; in1 = 1'b0;
  endtask

  task automatic run_job(input int ndirs, input bit drop_req, output int who);
    int guard;
    guard = 0;
    while (!(gnt0 || gnt1) && guard < 20) begin step(); guard++; end
    if (!(gnt0 || gnt1)) begin hang_n++; who = -1; return; end
    who = gnt1 ? 1 : 0;
    if (drop_req) begin if (who == 0) req0 = 1'b0; else req1 = 1'b0; end
    load_only(who, MAZE_CELLS, 3);
    repeat ($urandom_range(1, 8)) step();
    for (int i = 0; i < ndirs; i++) begin
      logic [1:0] d;
      d = 2'($urandom);
      slv_out_valid = 1'b1; slv_out = d;
      if (who == 0) exp_d0.push_back(d); else exp_d1.push_back(d);
      step();
    end
    slv_out_valid = 1'b0; slv_out = 2'd0;
    guard = 0;
    do begin step(); guard++; end while (!done && guard < 5);
    if (!done) hang_n++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({gnt0, gnt1, busy, done, err, slv_in_valid, slv_in, out_valid0, out_valid1, out0, out1} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all zero",
               {gnt0, gnt1, busy, done, err, slv_in_valid, slv_in, out_valid0, out_valid1, out0, out1});
    end
    rst_n = 1'b1;
    rr_last = 1;
    step();
    n_checks++;
    if (busy !== 1'b0 || gnt0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b gnt0=%b required 0 0", busy, gnt0);
    end
  endtask

  task automatic test_single_req0();
    int who, d;
    clear_mon();
    req0 = 1'b1;
    n_checks++;
    if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_pre_gnt: gnt0=%b required 0", gnt0); end
    step();
    n_checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_gnt_latency: gnt0=%b gnt1=%b busy=%b required 1 0 1", gnt0, gnt1, busy);
    end
    run_job(30, 1'b1, who);
    rr_last = 0;
    n_checks++;
    if (who !== 0 || hang_n !== 0) begin n_fail++; $display("FAIL single_owner: who=%0d hangs=%0d required 0 0", who, hang_n); end
    n_checks++;
    if (done !== 1'b1 || out_valid0 !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done_cycle: done=%b out_valid0=%b gnt0=%b busy=%b required 1 0 0 0", done, out_valid0, gnt0, busy);
    end
    repeat (3) step();
    n_checks++;
    d = diff_bits(slv_q, exp_bits);
    if (d != -1) begin
      n_fail++; $display("FAIL single_slv_stream: got %0d bits required %0d, first diff %0d", slv_q.size(), exp_bits.size(), d);
    end
    n_checks++;
    d = diff_dirs(o_q0, exp_d0);
    if (d != -1) begin
      n_fail++; $display("FAIL single_out0_stream: got %0d dirs required %0d, first diff %0d", o_q0.size(), exp_d0.size(), d);
    end
    n_checks++;
    if (o_q1.size() != 0 || leak_n != 0) begin
      n_fail++; $display("FAIL single_isolation: out1 count=%0d leaks=%0d required 0 0", o_q1.size(), leak_n);
    end
    n_checks++;
    if (done_n != 1 || err_n != 0 || gnt0 !== 1'b0) begin
      n_fail++; $display("FAIL single_pulses: done=%0d err=%0d gnt0=%b required 1 0 0", done_n, err_n, gnt0);
    end
  endtask

  task automatic test_both_from_reset();
    int e1, e2, w1, w2;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    rr_last = 1;
    step();
    clear_mon();
    req0 = 1'b1; req1 = 1'b1;
    e1 = pick(1'b1, 1'b1);
    step();
    n_checks++;
    if (gnt0 !== (e1 == 0) || gnt1 !== (e1 == 1)) begin
      n_fail++; $display("FAIL both_first_gnt: gnt0=%b gnt1=%b required winner %0d", gnt0, gnt1, e1);
    end
    run_job($urandom_range(5, 20), 1'b1, w1);
    rr_last = e1;
    n_checks++;
    if (gnt1 !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL both_idle_gap: gnt1=%b busy=%b required 0 0", gnt1, busy);
    end
    e2 = pick(req0, req1);
    run_job($urandom_range(5, 20), 1'b1, w2);
    rr_last = e2;
    n_checks++;
    if (w1 != e1 || w2 != e2 || gap_bad != 0 || hang_n != 0) begin
      n_fail++; $display("FAIL both_order: got %0d,%0d gap_bad=%0d hangs=%0d required %0d,%0d 0 0", w1, w2, gap_bad, hang_n, e1, e2);
    end
    n_checks++;
    if (done_n != 2 || diff_dirs(o_q1, exp_d1) != -1 || diff_dirs(o_q0, exp_d0) != -1) begin
      n_fail++; $display("FAIL both_streams: done=%0d out0=%0d/%0d out1=%0d/%0d required 2 and matching",
                         done_n, o_q0.size(), exp_d0.size(), o_q1.size(), exp_d1.size());
    end
  endtask

  task automatic test_back_to_back();
    int exp_hist[$];
    int who, e, d;
    clear_mon();
    req0 = 1'b1; req1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      e = pick(1'b1, 1'b1);
      exp_hist.push_back(e);
      if (j == 3) begin
        run_job($urandom_range(1, 12), 1'b0, who);
        req0 = 1'b0; req1 = 1'b0;
      end else begin
        run_job($urandom_range(1, 12), 1'b0, who);
      end
      rr_last = e;
    end
    n_checks++;
    if (gnt_hist != exp_hist) begin
      n_fail++; $display("FAIL b2b_grant_order: got %p required %p", gnt_hist, exp_hist);
    end
    n_checks++;
    if (gap_bad != 0 || done_n != 4 || err_n != 0 || both_n != 0 || hang_n != 0) begin
      n_fail++; $display("FAIL b2b_pulses: gap_bad=%0d done=%0d err=%0d both=%0d hangs=%0d required 0 4 0 0 0",
                         gap_bad, done_n, err_n, both_n, hang_n);
    end
    n_checks++;
    d = diff_bits(slv_q, exp_bits);
    if (d != -1 || diff_dirs(o_q0, exp_d0) != -1 || diff_dirs(o_q1, exp_d1) != -1 || leak_n != 0) begin
      n_fail++; $display("FAIL b2b_streams: bits %0d/%0d diff %0d out0 %0d/%0d out1 %0d/%0d leaks=%0d",
                         slv_q.size(), exp_bits.size(), d, o_q0.size(), exp_d0.size(), o_q1.size(), exp_d1.size(), leak_n);
    end
  endtask

  task automatic test_timeout();
    int k;
    clear_mon();
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    n_checks++;
    if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL timeout_gnt: gnt1=%b required 1", gnt1); end
    load_only(1, MAZE_CELLS, 0);
    n_checks++;
    if (slv_in_valid !== 1'b1 || slv_q.size() != MAZE_CELLS) begin
      n_fail++; $display("FAIL timeout_last_bit: slv_in_valid=%b count=%0d required 1 %0d", slv_in_valid, slv_q.size(), MAZE_CELLS);
    end
    k = 0;
    do begin step(); k++; end while (!err && k < TIMEOUT + 10);
    rr_last = 1;
    n_checks++;
    if (k != TIMEOUT || err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_cycles: err after %0d cycles (err=%b) required %0d", k, err, TIMEOUT);
    end
    n_checks++;
    if (gnt1 !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_release: gnt1=%b busy=%b done=%b required 0 0 0", gnt1, busy, done);
    end
    step();
    n_checks++;
    if (err !== 1'b0 || err_n != 1 || done_n != 0) begin
      n_fail++; $display("FAIL timeout_pulse: err=%b err_count=%0d done_count=%0d required 0 1 0", err, err_n, done_n);
    end
  endtask

  task automatic test_drop();
    clear_mon();
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    n_checks++;
    if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL drop_gnt: gnt0=%b required 1", gnt0); end
    load_only(0, 100, 0);
    step();
    rr_last = 0;
    n_checks++;
    if (err !== 1'b1 || done !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_abort: err=%b done=%b gnt0=%b busy=%b required 1 0 0 0", err, done, gnt0, busy);
    end
    repeat (10) step();
    n_checks++;
    if (slv_q.size() != 100 || diff_bits(slv_q, exp_bits) != -1 || err_n != 1 || done_n != 0) begin
      n_fail++; $display("FAIL drop_after: bits=%0d err_count=%0d done_count=%0d required 100 1 0", slv_q.size(), err_n, done_n);
    end
  endtask

  task automatic test_reset_drain();
    int who;
    clear_mon();
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    load_only(1, MAZE_CELLS, 0);
    step(); step();
    slv_out_valid = 1'b1; slv_out = 2'($urandom);
    step(); step();
    n_checks++;
    if (out_valid1 !== 1'b1 || gnt1 !== 1'b1) begin
      n_fail++; $display("FAIL rstdrain_in_drain: out_valid1=%b gnt1=%b required 1 1", out_valid1, gnt1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt0, gnt1, busy, done, err, slv_in_valid, slv_in, out_valid0, out_valid1, out0, out1} !== 13'd0) begin
      n_fail++; $display("FAIL rstdrain_async: got %b required all zero",
                         {gnt0, gnt1, busy, done, err, slv_in_valid, slv_in, out_valid0, out_valid1, out0, out1});
    end
    slv_out_valid = 1'b0; slv_out = 2'd0;
    step(); step();
    rst_n = 1'b1;
    rr_last = 1;
    step();
    n_checks++;
    if (done_n != 0 || err_n != 0) begin
      n_fail++; $display("FAIL rstdrain_no_pulse: done=%0d err=%0d required 0 0", done_n, err_n);
    end
    clear_mon();
    req0 = 1'b1; req1 = 1'b1;
    step();
    req1 = 1'b0;
    n_checks++;
    if (gnt0 !== (pick(1'b1, 1'b1) == 0) || gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL rstdrain_rr_restart: gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
    end
    run_job($urandom_range(3, 15), 1'b1, who);
    rr_last = 0;
    n_checks++;
    if (who != 0 || done_n != 1 || err_n != 0 || diff_dirs(o_q0, exp_d0) != -1 || diff_bits(slv_q, exp_bits) != -1) begin
      n_fail++; $display("FAIL rstdrain_next_job: who=%0d done=%0d err=%0d dirs %0d/%0d bits %0d/%0d",
                         who, done_n, err_n, o_q0.size(), exp_d0.size(), slv_q.size(), exp_bits.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_req0();
    test_both_from_reset();
    test_back_to_back();
    test_timeout();
    test_drop();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_arb.md
MAZE_ARB -- requirements
Module: maze_arb

Interface
REQ-001 The block SHALL have parameter MAZE_CELLS, default 289, meaning the number of serial maze bits per job (17x17).
REQ-002 The block SHALL have parameter TIMEOUT, default 4095, meaning the maximum number of SOLVE cycles to wait for the solver's first out_valid.
REQ-003 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1 each  requester N wants to submit a maze.
- in_valid0, in_valid1  in  1 each  requester N maze bit valid.
- in0, in1  in  1 each  requester N maze bit (0 = path, 1 = wall).
- gnt0, gnt1  out  1 each  requester N owns the solver.
- slv_in_valid  out  1  forwarded bit valid to the solver.
- slv_in  out  1  forwarded maze bit to the solver.
- slv_out_valid  in  1  solver direction valid.
- slv_out  in  2  solver direction (0 right, 1 down, 2 left, 3 up).
- out_valid0, out_valid1  out  1 each  returned direction valid to requester N.
- out0, out1  out  2 each  returned direction to requester N.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle pulse when a job completes normally.
- err  out  1  one-cycle pulse when a job aborts.

Function
REQ-004 The FSM SHALL have four states: IDLE, LOAD, SOLVE and DRAIN.
REQ-005 In IDLE with any req high, the block SHALL move to LOAD next cycle and assert exactly one gnt at that edge, giving 1-cycle req-to-gnt latency.
REQ-006 Arbitration SHALL be round-robin: if both req are high, the requester not served last SHALL win; last-served SHALL reset to 1, so req0 wins first.
REQ-007 A gnt SHALL stay high through LOAD, SOLVE and DRAIN, and SHALL be low in IDLE.
REQ-008 In LOAD, the block SHALL wait for the granted requester's first in_valid, then count valid bits with a 9-bit counter.
REQ-009 Each granted bit SHALL appear on slv_in_valid/slv_in exactly one cycle after it is sampled (registered forward).
REQ-010 The non-granted requester's in_valid/in SHALL be ignored, and slv_in_valid SHALL never reflect it.
REQ-011 The block SHALL move from LOAD to SOLVE on the cycle the MAZE_CELLS-th bit is sampled; any in_valid beyond the count SHALL be ignored.
REQ-012 If in_valid falls in LOAD after the first bit and before the count is reached, the block SHALL pulse err, drop gnt, go to IDLE, and update last-served.
REQ-013 In SOLVE, a 12-bit timeout counter SHALL increment each cycle.
REQ-014 In SOLVE, slv_out_valid high SHALL move the block to DRAIN; if the counter reaches TIMEOUT first, the block SHALL pulse err and go to IDLE.
REQ-015 In SOLVE and DRAIN, out_validN/outN of the granted requester SHALL equal slv_out_valid/slv_out delayed one cycle; the other requester's outputs SHALL stay 0.
REQ-016 When slv_out_valid goes low in DRAIN, the block SHALL pulse done on the following cycle, concurrent with out_validN low, then go to IDLE and update last-served.
REQ-017 A req arriving while busy SHALL be held pending, with no drop or queue depth beyond the level req signal, and SHALL be arbitrated in the first IDLE cycle.
REQ-018 done and err SHALL be mutually exclusive, and each SHALL be exactly one cycle wide.
REQ-019 Between jobs, IDLE SHALL last at least one cycle, and busy SHALL be low for that cycle.

Reset
REQ-020 When rst_n is low, the block SHALL set the state to IDLE, all outputs to 0, both counters to 0, and last-served to 1, asynchronously.
REQ-021 Reset asserted mid-job in any state SHALL abort the job with no done or err pulse, and the block SHALL accept a new req normally after release.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- req0 only, 289 contiguous bits, solver returns 30 directions -> gnt0 at +1 cycle; slv_in mirrors in0 delayed 1 cycle for all 289 bits; out0 carries 30 directions delayed 1; done pulses once; gnt0 falls.
- req0 and req1 rise together from reset -> gnt0 first; after done, req1 still high -> gnt1 with at least one IDLE cycle between grants.
- Back-to-back jobs with both requesters always requesting -> grants alternate 0,1,0,1.
- Granted requester drops in_valid after 100 bits -> err pulse, no done, gnt low, slv_in_valid low thereafter.
- Solver never responds -> err pulse exactly TIMEOUT SOLVE cycles after the 289th bit; the block returns to IDLE.
- rst_n pulsed low during DRAIN -> all outputs 0 immediately; the next req0 is served normally, with round-robin restarted from req0.
